// File: rtl/frame_dump_tx_if.sv
// Buffer read port and UART transmit handshake used by frame_dump_tx.
// The master side is the frame streamer; the slave side is the buffer plus UART.
interface frame_dump_tx_if #(
    parameter int unsigned X_W = 6,
    parameter int unsigned Y_W = 5
);
    logic [X_W-1:0] read_x;
    logic [Y_W-1:0] read_y;
    logic [31:0]    read_q;
    logic           uart_busy;
    logic           uart_wr;
    logic [7:0]     uart_dat;

    modport master (
        output read_x,
        output read_y,
        input  read_q,
        input  uart_busy,
        output uart_wr,
        output uart_dat
    );

    modport slave (
        input  read_x,
        input  read_y,
        output read_q,
        output uart_busy,
        input  uart_wr,
        input  uart_dat
    );
endinterface

// File: rtl/frame_dump_tx.sv
// Streams one buffered frame over the debug UART: 2 sync bytes, COLS*ROWS words
// MSB byte first, then an 8-bit sum of the payload bytes.
module frame_dump_tx #(
    parameter int unsigned COLS         = 40,
    parameter int unsigned ROWS         = 30,
    parameter int unsigned X_W          = 6,
    parameter int unsigned Y_W          = 5,
    parameter int unsigned HOLDOFF_W    = 13,
    parameter logic [7:0]  SYNC0        = 8'hA5,
    parameter logic [7:0]  SYNC1        = 8'h5A,
    parameter bit          AUTO_RESTART = 1'b1
) (
    input  logic                   sys_clk_i,
    input  logic                   sys_rst_i,
    input  logic                   start_i,
    frame_dump_tx_if.master        bus_io,
    output logic                   busy_o,
    output logic                   frame_done_o
);

    localparam logic [X_W-1:0] XLast = X_W'(COLS - 1);
    localparam logic [Y_W-1:0] YLast = Y_W'(ROWS - 1);

    typedef enum logic [2:0] {
        StIdle, StHdr0, StHdr1, StFetch, StLatch, StSend, StCsum, StDone
    } state_e;

    state_e               state_q, state_d;
    logic [X_W-1:0]       x_q, x_d;
    logic [Y_W-1:0]       y_q, y_d;
    logic [1:0]           byte_idx_q, byte_idx_d;
    logic [31:0]          word_q, word_d;
    logic [7:0]           csum_q, csum_d;
    logic [HOLDOFF_W-1:0] holdoff_q, holdoff_d;
    logic                 wr_q, wr_d;
    logic [7:0]           dat_q, dat_d;
    logic                 done_q, done_d;
    logic                 can_send;
    logic [7:0]           payload_byte;

    // A byte may go out only after the line has been quiet for a full holdoff period.
    assign can_send = (&holdoff_q) & ~bus_io.uart_busy & ~wr_q;

    always_comb begin
        if (bus_io.uart_busy || wr_q) begin
            holdoff_d = '0;
        end else if (&holdoff_q) begin
            holdoff_d = holdoff_q;
        end else begin
            holdoff_d = holdoff_q + 1'b1;
        end
    end

    always_comb begin
        payload_byte = word_q[31:24];
        unique case (byte_idx_q)
            2'd0: payload_byte = word_q[31:24];
            2'd1: payload_byte = word_q[23:16];
            2'd2: payload_byte = word_q[15:8];
            2'd3: payload_byte = word_q[7:0];
        endcase
    end

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        byte_idx_d = byte_idx_q;
        word_d     = word_q;
        csum_d     = csum_q;
        wr_d       = 1'b0;
        dat_d      = dat_q;
        done_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i || AUTO_RESTART) begin
                    x_d     = '0;
                    y_d     = '0;
                    csum_d  = '0;
                    state_d = StHdr0;
                end
            end
            StHdr0: begin
                if (can_send) begin
                    wr_d    = 1'b1;
                    dat_d   = SYNC0;
                    state_d = StHdr1;
                end
            end
            StHdr1: begin
                if (can_send) begin
                    wr_d    = 1'b1;
                    dat_d   = SYNC1;
                    state_d = StFetch;
                end
            end
            // The address is already on x_q/y_q; the buffer returns data next cycle.
            StFetch: state_d = StLatch;
            StLatch: begin
                word_d     = bus_io.read_q;
                byte_idx_d = 2'd0;
                state_d    = StSend;
            end
            StSend: begin
                if (can_send) begin
                    wr_d       = 1'b1;
                    dat_d      = payload_byte;
                    csum_d     = csum_q + payload_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        if (x_q == XLast && y_q == YLast) begin
                            state_d = StCsum;
                        end else if (x_q == XLast) begin
                            x_d     = '0;
                            y_d     = y_q + 1'b1;
                            state_d = StFetch;
                        end else begin
                            x_d     = x_q + 1'b1;
                            state_d = StFetch;
                        end
                    end
                end
            end
            StCsum: begin
                if (can_send) begin
                    wr_d    = 1'b1;
                    dat_d   = csum_q;
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q    <= StIdle;
            x_q        <= '0;
            y_q        <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
            csum_q     <= '0;
            holdoff_q  <= '0;
            wr_q       <= 1'b0;
            dat_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
            csum_q     <= csum_d;
            holdoff_q  <= holdoff_d;
            wr_q       <= wr_d;
            dat_q      <= dat_d;
            done_q     <= done_d;
        end
    end

    assign bus_io.read_x   = x_q;
    assign bus_io.read_y   = y_q;
    assign bus_io.uart_wr  = wr_q;
    assign bus_io.uart_dat = dat_q;
    assign busy_o          = (state_q != StIdle);
    assign frame_done_o    = done_q;

endmodule
